polar_node_pe: RTL and testbench

- Multi-lane, pipelined LLR processing element for the successive-cancellation polar decoder datapath.
- Each accepted vector is processed in one of two modes:
  - f-node: min-sum check update, with optional offset.
  - g-node: variable update using partial-sum bits.
- Outputs are symmetric-saturated.
- Sits between the LLR memory read port and the write-back path. It uses a valid/ready handshake on both sides and carries a processed-vector counter for debug and throughput monitoring.

---
 rtl/polar_node_pe_if.sv | 30 +++
 rtl/polar_node_pe.sv | 134 +++++++++++++
 tb/tb_polar_node_pe.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/polar_node_pe_if.sv
// Handshake and data bundle between the LLR memory read port, the polar PE and the write-back path.
// master drives input vectors and out_ready; slave is the PE.
interface polar_node_pe_if #(
  parameter int SIZE  = 8,
  parameter int LANES = 8,
  parameter int CNT_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    mode;
  logic [SIZE-2:0]         offset;
  logic [LANES*SIZE-1:0]   llr_a;
  logic [LANES*SIZE-1:0]   llr_b;
  logic [LANES-1:0]        beta;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*SIZE-1:0]   llr_out;
  logic                    out_mode;
  logic [CNT_W-1:0]        vec_count;

  modport master (
    output in_valid, mode, offset, llr_a, llr_b, beta, out_ready,
    input  in_ready, out_valid, llr_out, out_mode, vec_count
  );

  modport slave (
    input  in_valid, mode, offset, llr_a, llr_b, beta, out_ready,
    output in_ready, out_valid, llr_out, out_mode, vec_count
  );
endinterface

// File: rtl/polar_node_pe.sv
// Two-stage multi-lane polar PE: f-node (offset min-sum) or g-node (partial-sum add), symmetric-saturated.
// Result is valid the cycle after S1 is loaded; in_ready = stage free, no skid buffer, so at most two vectors in flight.
module polar_node_pe #(
  parameter int SIZE  = 8,
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  polar_node_pe_if.slave   pe
);

  localparam logic signed [SIZE-1:0] L_MAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic signed [SIZE-1:0] L_MIN = {1'b1, {(SIZE-2){1'b0}}, 1'b1};
  localparam logic signed [SIZE-1:0] L_NEG = {1'b1, {(SIZE-1){1'b0}}};
  localparam logic signed [SIZE:0]   G_MAX = {2'b00, {(SIZE-1){1'b1}}};
  localparam logic signed [SIZE:0]   G_MIN = {2'b11, {(SIZE-2){1'b0}}, 1'b1};
  localparam logic [SIZE-2:0]        ONE   = {{(SIZE-2){1'b0}}, 1'b1};

  // -2^(SIZE-1) has no positive counterpart, so fold it onto MIN before anything else
  function automatic logic signed [SIZE-1:0] clamp(input logic signed [SIZE-1:0] x);
    return (x == L_NEG) ? L_MIN : x;
  endfunction

  logic adv1, adv2;
  logic s1_valid, s2_valid;

  // S1 combinational front end
  logic signed [SIZE-1:0] c_a     [LANES];
  logic signed [SIZE-1:0] c_b     [LANES];
  logic [SIZE-2:0]        c_abs_a [LANES];
  logic [SIZE-2:0]        c_abs_b [LANES];
  logic [LANES-1:0]       c_sgn;
  logic signed [SIZE:0]   c_gsum  [LANES];

  always_comb begin
    c_sgn = '0;
    for (int i = 0; i < LANES; i++) begin
      c_a[i]     = clamp(pe.llr_a[i*SIZE +: SIZE]);
      c_b[i]     = clamp(pe.llr_b[i*SIZE +: SIZE]);
      c_abs_a[i] = c_a[i][SIZE-1] ? (~c_a[i][SIZE-2:0] + ONE) : c_a[i][SIZE-2:0];
      c_abs_b[i] = c_b[i][SIZE-1] ? (~c_b[i][SIZE-2:0] + ONE) : c_b[i][SIZE-2:0];
      c_sgn[i]   = c_a[i][SIZE-1] ^ c_b[i][SIZE-1];
      c_gsum[i]  = {c_b[i][SIZE-1], c_b[i]} +
                   (pe.beta[i] ? -{c_a[i][SIZE-1], c_a[i]} : {c_a[i][SIZE-1], c_a[i]});
    end
  end

  // S1 registers
  logic                   s1_mode;
  logic [SIZE-2:0]        s1_off;
  logic [SIZE-2:0]        s1_abs_a [LANES];
  logic [SIZE-2:0]        s1_abs_b [LANES];
  logic [LANES-1:0]       s1_sgn;
  logic signed [SIZE:0]   s1_gsum  [LANES];

  assign adv2 = !s2_valid || pe.out_ready;
  assign adv1 = !s1_valid || adv2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_off   <= '0;
      s1_sgn   <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_abs_a[i] <= '0;
        s1_abs_b[i] <= '0;
        s1_gsum[i]  <= '0;
      end
    end else begin
      if (adv1) s1_valid <= pe.in_valid;
      if (adv1 && pe.in_valid) begin
        s1_mode <= pe.mode;
        s1_off  <= pe.offset;
        s1_sgn  <= c_sgn;
        for (int i = 0; i < LANES; i++) begin
          s1_abs_a[i] <= c_abs_a[i];
          s1_abs_b[i] <= c_abs_b[i];
          s1_gsum[i]  <= c_gsum[i];
        end
      end
    end
  end

  // S2 combinational back end: offset, sign and saturation
  logic [SIZE-2:0]       c_min [LANES];
  logic [SIZE-2:0]       c_mag [LANES];
  logic [LANES*SIZE-1:0] c_out;

  always_comb begin
    c_out = '0;
    for (int i = 0; i < LANES; i++) begin
      c_min[i] = (s1_abs_a[i] < s1_abs_b[i]) ? s1_abs_a[i] : s1_abs_b[i];
      c_mag[i] = (c_min[i] > s1_off) ? (c_min[i] - s1_off) : '0;
      if (s1_mode) begin
        if (s1_gsum[i] > G_MAX)      c_out[i*SIZE +: SIZE] = L_MAX;
        else if (s1_gsum[i] < G_MIN) c_out[i*SIZE +: SIZE] = L_MIN;
        else                         c_out[i*SIZE +: SIZE] = s1_gsum[i][SIZE-1:0];
      end else begin
        // a zero magnitude negates to zero, so the result is never a negative zero
        c_out[i*SIZE +: SIZE] = s1_sgn[i] ? -{1'b0, c_mag[i]} : {1'b0, c_mag[i]};
      end
    end
  end

  // S2 registers and delivered-vector counter
  logic [LANES*SIZE-1:0] s2_llr;
  logic                  s2_mode;
  logic [CNT_W-1:0]      cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_llr   <= '0;
      s2_mode  <= 1'b0;
      cnt      <= '0;
    end else begin
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        s2_llr  <= c_out;
        s2_mode <= s1_mode;
      end
      if (s2_valid && pe.out_ready) cnt <= cnt + CNT_W'(1);
    end
  end

  assign pe.in_ready  = adv1;
  assign pe.out_valid = s2_valid;
  assign pe.llr_out   = s2_llr;
  assign pe.out_mode  = s2_mode;
  assign pe.vec_count = cnt;

endmodule

// File: tb/tb_polar_node_pe.sv
// Scoreboard bench for polar_node_pe: directed vectors push expected results, a negedge monitor pops and compares.
module tb_polar_node_pe;
  localparam int SIZE  = 8;
  localparam int LANES = 8;
  localparam int CNT_W = 4;

  typedef int lane_t [LANES];
  typedef struct {
    logic [LANES*SIZE-1:0] llr;
    logic                  mode;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  polar_node_pe_if #(.SIZE(SIZE), .LANES(LANES), .CNT_W(CNT_W)) ifc ();

  polar_node_pe #(.SIZE(SIZE), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pe    (ifc.slave)
  );

  exp_t              sb[$];
  int                xfer_cyc[$];
  int                n_chk = 0;
  int                n_fail = 0;
  int                cyc = 0;
  logic [CNT_W-1:0]  exp_cnt = '0;
  logic              stall = 1'b0;
  logic [LANES*SIZE-1:0] hold_llr = '0;
  logic              hold_mode = 1'b0;
  lane_t             z = '{default: 0};

  function automatic logic [LANES*SIZE-1:0] pk(input lane_t v);
    logic [LANES*SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*SIZE +: SIZE] = v[i][SIZE-1:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // monitor: every delivered result is compared against the oldest expected entry
  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall && ifc.out_valid) begin
        n_chk++;
        if (ifc.llr_out !== hold_llr || ifc.out_mode !== hold_mode) begin
          n_fail++;
          $display("FAIL stall_hold: got %h/%b, expected %h/%b", ifc.llr_out, ifc.out_mode, hold_llr, hold_mode);
        end
      end
      if (ifc.out_valid && ifc.out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h, expected no output", ifc.llr_out);
        end else begin
          e = sb.pop_front();
          if (ifc.llr_out !== e.llr || ifc.out_mode !== e.mode) begin
            n_fail++;
            $display("FAIL result: got %h mode %b, expected %h mode %b", ifc.llr_out, ifc.out_mode, e.llr, e.mode);
          end
          n_chk++;
          if (ifc.vec_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL vec_count_run: got %0d, expected %0d", ifc.vec_count, exp_cnt);
          end
          exp_cnt = exp_cnt + 1'b1;
          xfer_cyc.push_back(cyc);
        end
      end
      stall     = ifc.out_valid && !ifc.out_ready;
      hold_llr  = ifc.llr_out;
      hold_mode = ifc.out_mode;
    end
  end

  task automatic send(input logic md, input logic [SIZE-2:0] off, input lane_t a, input lane_t b,
                      input logic [LANES-1:0] bt, input lane_t e);
    int   t;
    exp_t x;
    t = 0;
    ifc.in_valid = 1'b1;
    ifc.mode     = md;
    ifc.offset   = off;
    ifc.llr_a    = pk(a);
    ifc.llr_b    = pk(b);
    ifc.beta     = bt;
    @(negedge clk);
    while (!ifc.in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!ifc.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
    end else begin
      x.llr  = pk(e);
      x.mode = md;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  // idle with junk on the data inputs, which must not disturb anything
  task automatic idle();
    logic [31:0] r;
    r = $urandom();
    ifc.in_valid = 1'b0;
    ifc.mode     = r[0];
    ifc.offset   = r[7:1];
    ifc.beta     = r[15:8];
    ifc.llr_a    = {$urandom(), $urandom()};
    ifc.llr_b    = {$urandom(), $urandom()};
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || ifc.out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || ifc.out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ifc.out_ready = 1'b1;
    idle();
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_llr_out",   64'(ifc.llr_out),   64'd0);
    chk("rst_vec_count", 64'(ifc.vec_count), 64'd0);
    chk("rst_in_ready",  64'(ifc.in_ready),  64'd1);
    @(posedge clk);
    #1;

    // f mode, no offset, plus latency through the two stages
    send(1'b0, 7'd0, '{-5, 7, 0, 0, 0, 0, 0, 0}, '{3, 7, -9, 0, 0, 0, 0, 0}, 8'h00,
         '{-3, 7, 0, 0, 0, 0, 0, 0});
    idle();
    chk("lat_after_accept", 64'(ifc.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(ifc.out_valid), 64'd1);
    wait_drain();

    // f mode with offset, including the -128 entry clamp
    send(1'b0, 7'd1, '{-5, 1, -128, 0, 0, 0, 0, 0}, '{3, -40, -128, 0, 0, 0, 0, 0}, 8'h00,
         '{-2, 0, 126, 0, 0, 0, 0, 0});
    idle();
    wait_drain();

    // g mode saturation and beta handling
    send(1'b1, 7'd0, '{100, 100, -128, 3, 0, 0, 0, 0}, '{100, -100, 0, 4, 0, 0, 0, 0}, 8'b0000_1110,
         '{127, -127, 127, 1, 0, 0, 0, 0});
    idle();
    wait_drain();

    // backpressure: two in flight, then in_ready must drop
    do_reset();
    ifc.out_ready = 1'b0;
    send(1'b1, 7'd0, '{1, 0, 0, 0, 0, 0, 0, 0},  '{2, 0, 0, 0, 0, 0, 0, 0}, 8'h00, '{3, 0, 0, 0, 0, 0, 0, 0});
    send(1'b1, 7'd0, '{11, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0}, 8'h00, '{13, 0, 0, 0, 0, 0, 0, 0});
    fork
      send(1'b1, 7'd0, '{21, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0}, 8'h00, '{23, 0, 0, 0, 0, 0, 0, 0});
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", 64'(ifc.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
      end
    join
    send(1'b1, 7'd0, '{31, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0}, 8'h00, '{33, 0, 0, 0, 0, 0, 0, 0});
    idle();
    wait_drain();
    chk("bp_vec_count", 64'(ifc.vec_count), 64'd4);

    // alternating f/g back to back must stream without bubbles
    xfer_cyc.delete();
    send(1'b0, 7'd0, '{-20, 0, 0, 0, 0, 0, 0, 0}, '{6, 0, 0, 0, 0, 0, 0, 0},   8'h00, '{-6, 0, 0, 0, 0, 0, 0, 0});
    send(1'b1, 7'd0, '{5, 0, 0, 0, 0, 0, 0, 0},   '{-9, 0, 0, 0, 0, 0, 0, 0},  8'h01, '{-14, 0, 0, 0, 0, 0, 0, 0});
    send(1'b0, 7'd2, '{50, 0, 0, 0, 0, 0, 0, 0},  '{-60, 0, 0, 0, 0, 0, 0, 0}, 8'h00, '{-48, 0, 0, 0, 0, 0, 0, 0});
    send(1'b1, 7'd0, '{-7, 0, 0, 0, 0, 0, 0, 0},  '{3, 0, 0, 0, 0, 0, 0, 0},   8'h00, '{-4, 0, 0, 0, 0, 0, 0, 0});
    idle();
    wait_drain();
    chk("b2b_count", 64'(xfer_cyc.size()), 64'd4);
    for (int i = 1; i < xfer_cyc.size(); i++)
      chk("b2b_no_bubble", 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'd1);

    // asynchronous reset with two vectors in flight
    do_reset();
    for (int i = 0; i < 5; i++) send(1'b0, 7'd0, z, z, 8'h00, z);
    idle();
    wait_drain();
    chk("pre_rst_vec_count", 64'(ifc.vec_count), 64'd5);
    ifc.out_ready = 1'b0;
    send(1'b0, 7'd0, '{9, 0, 0, 0, 0, 0, 0, 0},  '{9, 0, 0, 0, 0, 0, 0, 0}, 8'h00, '{9, 0, 0, 0, 0, 0, 0, 0});
    send(1'b0, 7'd0, '{-9, 0, 0, 0, 0, 0, 0, 0}, '{9, 0, 0, 0, 0, 0, 0, 0}, 8'h00, '{-9, 0, 0, 0, 0, 0, 0, 0});
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("midrst_llr_out",   64'(ifc.llr_out),   64'd0);
    chk("midrst_vec_count", 64'(ifc.vec_count), 64'd0);
    sb.delete();
    exp_cnt = '0;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready",  64'(ifc.in_ready),  64'd1);
    chk("post_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;

    // counter wrap with a 4-bit counter: 17 deliveries land on 1
    for (int i = 0; i < 17; i++) begin
      lane_t v;
      v = '{default: 0};
      v[0] = i;
      send(1'b0, 7'd0, v, v, 8'h00, v);
    end
    idle();
    wait_drain();
    chk("wrap_vec_count", 64'(ifc.vec_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
